// File: rtl/snn_seq_pkg.sv
// Shared definitions for the SNN layer sequencer: state encoding and default watchdog limit.
package snn_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_ADV   = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLR   = ST_CLR,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_ADV   = ST_ADV,
    S_FIN   = ST_FIN
  } seq_state_e;

  localparam int TO_CYCLES_DEF = 4096;

endpackage

// File: rtl/snn_seq_wdog.sv
// Per-layer wait watchdog: counts enabled cycles, clears synchronously, flags the
// last permitted cycle. Built only when SNN_SEQ_WDOG_EN is defined.
module snn_seq_wdog
  import snn_seq_pkg::*;
#(
  parameter int TC = TO_CYCLES_DEF,
  parameter int CW = $clog2(TC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(TC - 1));
  assign o_tc   = i_en & w_last;

  // Cycle counter; saturates at the terminal value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/snn_layer_seq.sv
// Network-level scheduler: clears membranes, then sweeps start/done handshakes over
// every layer for T_STEPS timesteps. Optional watchdog: define SNN_SEQ_WDOG_EN.
module snn_layer_seq
  import snn_seq_pkg::*;
#(
  parameter int N_LAYERS  = 3,
  parameter int T_STEPS   = 8,
  parameter int TW        = 4,
  parameter int LW        = 2,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic [N_LAYERS-1:0] i_layer_done,
  output logic [N_LAYERS-1:0] o_layer_start,
  output logic                o_mem_clr,
  output logic [TW-1:0]       o_tstep,
  output logic [LW-1:0]       o_layer_idx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic [TW-1:0]       r_tstep;
  logic [TW-1:0]       w_tstep_nxt;
  logic [LW-1:0]       r_layer_idx;
  logic [LW-1:0]       w_idx_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic [N_LAYERS-1:0] w_sel;
  logic [N_LAYERS-1:0] w_sel_nxt;
  logic                w_sel_done;
  logic                w_wdog_tc;
  logic [N_LAYERS-1:0] r_layer_start;
  logic                r_mem_clr;
  logic                r_busy;
  logic                r_done;

`ifdef SNN_SEQ_WDOG_EN
  snn_seq_wdog #(
    .TC (TO_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_state == S_WAIT),
    .i_clr (r_state != S_WAIT),
    .o_tc  (w_wdog_tc)
  );
`else
  assign w_wdog_tc = 1'b0;
`endif

  // One-hot decode of the current layer index; masks out non-selected done bits.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      w_sel[i] = (r_layer_idx == LW'(i));
    end
  end

  // One-hot decode of the next layer index, used to register the start pulse.
  always_comb begin
    w_sel_nxt = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      w_sel_nxt[i] = (w_idx_nxt == LW'(i));
    end
  end

  assign w_sel_done = |(i_layer_done & w_sel);

  // Next-state and counter update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_tstep_nxt = r_tstep;
    w_idx_nxt   = r_layer_idx;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_state_nxt = S_CLR;
          w_tstep_nxt = '0;
          w_idx_nxt   = '0;
          w_err_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLR:   w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // A real done wins over a watchdog expiry in the same cycle.
        if (w_sel_done) begin
          w_state_nxt = S_ADV;
        end else if (w_wdog_tc) begin
          w_state_nxt = S_FIN;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_ADV: begin
        if (r_layer_idx != LW'(N_LAYERS - 1)) begin
          w_idx_nxt   = r_layer_idx + LW'(1);
          w_state_nxt = S_ISSUE;
        end else if (r_tstep != TW'(T_STEPS - 1)) begin
          w_tstep_nxt = r_tstep + TW'(1);
          w_idx_nxt   = '0;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and Moore outputs, registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_tstep       <= '0;
      r_layer_idx   <= '0;
      r_err         <= 1'b0;
      r_layer_start <= '0;
      r_mem_clr     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tstep       <= w_tstep_nxt;
      r_layer_idx   <= w_idx_nxt;
      r_err         <= w_err_nxt;
      r_layer_start <= (w_state_nxt == S_ISSUE) ? w_sel_nxt : '0;
      r_mem_clr     <= (w_state_nxt == S_CLR);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (w_state_nxt == S_FIN);
    end
  end

  assign o_layer_start = r_layer_start;
  assign o_mem_clr     = r_mem_clr;
  assign o_tstep       = r_tstep;
  assign o_layer_idx   = r_layer_idx;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_snn_layer_seq.sv
// Directed bench for snn_layer_seq: a 3-layer/2-step instance and a 1-layer/1-step instance.
module tb_snn_layer_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_run = 1'b0;
  logic [2:0] i_layer_done = 3'b000;
  logic [2:0] o_layer_start;
  logic       o_mem_clr;
  logic [3:0] o_tstep;
  logic [1:0] o_layer_idx;
  logic       o_busy, o_done, o_err;

  logic       d1_run = 1'b0;
  logic [0:0] d1_layer_done = 1'b0;
  logic [0:0] d1_layer_start;
  logic       d1_mem_clr;
  logic [0:0] d1_tstep;
  logic [0:0] d1_layer_idx;
  logic       d1_busy, d1_done, d1_err;

  int errs = 0;
  int checks = 0;
  int n_clr = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  snn_layer_seq #(.N_LAYERS(3), .T_STEPS(2), .TW(4), .LW(2), .TO_CYCLES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_layer_done(i_layer_done),
    .o_layer_start(o_layer_start), .o_mem_clr(o_mem_clr), .o_tstep(o_tstep),
    .o_layer_idx(o_layer_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  snn_layer_seq #(.N_LAYERS(1), .T_STEPS(1), .TW(1), .LW(1), .TO_CYCLES(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_run(d1_run), .i_layer_done(d1_layer_done),
    .o_layer_start(d1_layer_start), .o_mem_clr(d1_mem_clr), .o_tstep(d1_tstep),
    .o_layer_idx(d1_layer_idx), .o_busy(d1_busy), .o_done(d1_done), .o_err(d1_err)
  );

  // Pulse counters for the main instance, sampled just before each rising edge.
  always @(posedge clk) begin
    if (o_mem_clr) n_clr++;
    if (o_done) n_done++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in a layer's ISSUE cycle; answers done 5 cycles after the start and
  // returns in the next ISSUE (or FIN) cycle, 7 cycles later.
  task automatic do_layer(input int idx, input int t, input logic [2:0] noise,
                          input logic rn, input logic iss);
    logic [2:0] e;
    e = 3'b001 << idx;
    chk("start_onehot", {29'd0, o_layer_start}, {29'd0, e});
    chk("start_tstep", {28'd0, o_tstep}, t);
    chk("start_lidx", {30'd0, o_layer_idx}, idx);
    i_layer_done = iss ? (e | noise) : noise;
    i_run = rn;
    step();
    i_layer_done = noise;
    chk("start_one_cycle", {29'd0, o_layer_start}, 32'd0);
    repeat (3) step();
    chk("wait_hold_lidx", {30'd0, o_layer_idx}, idx);
    chk("wait_busy", {31'd0, o_busy}, 32'd1);
    step();
    i_layer_done = e;
    i_run = 1'b0;
    step();
    i_layer_done = 3'b000;
    step();
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_start", {29'd0, o_layer_start}, 32'd0);
    chk("rst_mem_clr", {31'd0, o_mem_clr}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_tstep", {28'd0, o_tstep}, 32'd0);
    chk("rst_lidx", {30'd0, o_layer_idx}, 32'd0);
    rst_n = 1'b1;
    step();

    // Inference 1: plain 3x2 sweep
    n_clr = 0; n_done = 0;
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    chk("i1_mem_clr", {31'd0, o_mem_clr}, 32'd1);
    chk("i1_busy", {31'd0, o_busy}, 32'd1);
    chk("i1_clr_no_start", {29'd0, o_layer_start}, 32'd0);
    step();
    for (int t = 0; t < 2; t++) begin
      for (int l = 0; l < 3; l++) begin
        do_layer(l, t, 3'b000, 1'b0, 1'b0);
      end
    end
    chk("i1_fin_done", {31'd0, o_done}, 32'd1);
    chk("i1_fin_busy", {31'd0, o_busy}, 32'd1);
    chk("i1_fin_tstep", {28'd0, o_tstep}, 32'd1);
    chk("i1_fin_lidx", {30'd0, o_layer_idx}, 32'd2);
    step();
    chk("i1_idle_busy", {31'd0, o_busy}, 32'd0);
    chk("i1_idle_done", {31'd0, o_done}, 32'd0);
    chk("i1_hold_tstep", {28'd0, o_tstep}, 32'd1);
    chk("i1_hold_lidx", {30'd0, o_layer_idx}, 32'd2);
    chk("i1_n_clr", n_clr, 32'd1);
    chk("i1_n_done", n_done, 32'd1);
    chk("i1_err", {31'd0, o_err}, 32'd0);

    // Inference 2: foreign done, done in ISSUE, run while busy and in FIN
    n_clr = 0; n_done = 0;
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    chk("i2_mem_clr", {31'd0, o_mem_clr}, 32'd1);
    step();
    do_layer(0, 0, 3'b100, 1'b1, 1'b1);
    do_layer(1, 0, 3'b001, 1'b1, 1'b0);
    do_layer(2, 0, 3'b000, 1'b0, 1'b1);
    do_layer(0, 1, 3'b000, 1'b0, 1'b0);
    do_layer(1, 1, 3'b000, 1'b1, 1'b0);
    do_layer(2, 1, 3'b011, 1'b0, 1'b0);
    chk("i2_fin_done", {31'd0, o_done}, 32'd1);
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    chk("i2_fin_run_ignored", {31'd0, o_busy}, 32'd0);
    step();
    chk("i2_no_restart_busy", {31'd0, o_busy}, 32'd0);
    chk("i2_no_restart_clr", {31'd0, o_mem_clr}, 32'd0);
    chk("i2_n_done", n_done, 32'd1);
    chk("i2_n_clr", n_clr, 32'd1);

    // Inference 3: reset while waiting at tstep 1
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    chk("i3_mem_clr", {31'd0, o_mem_clr}, 32'd1);
    step();
    for (int l = 0; l < 3; l++) do_layer(l, 0, 3'b000, 1'b0, 1'b0);
    step();
    chk("i3_wait_tstep", {28'd0, o_tstep}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("i3_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("i3_rst_start", {29'd0, o_layer_start}, 32'd0);
    chk("i3_rst_tstep", {28'd0, o_tstep}, 32'd0);
    chk("i3_rst_lidx", {30'd0, o_layer_idx}, 32'd0);
    chk("i3_rst_done", {31'd0, o_done}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("i3_post_rst_idle", {31'd0, o_busy}, 32'd0);
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    chk("i3_restart_clr", {31'd0, o_mem_clr}, 32'd1);
    step();
    for (int t = 0; t < 2; t++) begin
      for (int l = 0; l < 3; l++) do_layer(l, t, 3'b000, 1'b0, 1'b0);
    end
    chk("i3_fin_done", {31'd0, o_done}, 32'd1);
    step();

`ifdef SNN_SEQ_WDOG_EN
    // Watchdog: layer 1 never answers
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    step();
    do_layer(0, 0, 3'b000, 1'b0, 1'b0);
    chk("wd_start1", {29'd0, o_layer_start}, 32'd2);
    repeat (16) step();
    chk("wd_no_done_yet", {31'd0, o_done}, 32'd0);
    chk("wd_no_err_yet", {31'd0, o_err}, 32'd0);
    step();
    chk("wd_done", {31'd0, o_done}, 32'd1);
    chk("wd_err", {31'd0, o_err}, 32'd1);
    step();
    chk("wd_idle", {31'd0, o_busy}, 32'd0);
    chk("wd_err_sticky", {31'd0, o_err}, 32'd1);
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    chk("wd_err_cleared", {31'd0, o_err}, 32'd0);
    chk("wd_rerun_clr", {31'd0, o_mem_clr}, 32'd1);
`else
    chk("no_wdog_err", {31'd0, o_err}, 32'd0);
`endif

    // Single layer, single timestep, done one cycle after start
    d1_run = 1'b1;
    step();
    d1_run = 1'b0;
    chk("d1_c1_clr", {31'd0, d1_mem_clr}, 32'd1);
    step();
    chk("d1_c2_start", {31'd0, d1_layer_start}, 32'd1);
    step();
    d1_layer_done = 1'b1;
    chk("d1_c3_wait", {31'd0, d1_layer_start}, 32'd0);
    step();
    d1_layer_done = 1'b0;
    chk("d1_c4_adv_nodone", {31'd0, d1_done}, 32'd0);
    step();
    chk("d1_c5_done", {31'd0, d1_done}, 32'd1);
    chk("d1_c5_busy", {31'd0, d1_busy}, 32'd1);
    step();
    chk("d1_c6_idle", {31'd0, d1_busy}, 32'd0);
    chk("d1_err", {31'd0, d1_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/snn_layer_seq.md
# snn_layer_seq

Network-level scheduler that sequences the per-layer LIF controllers of the SNN for one inference. It issues one-cycle start pulses to each layer in order, waits for that layer's done pulse, and repeats the layer sweep for T_STEPS timesteps. It clears all membrane state once at the start of an inference and signals completion with a one-cycle done pulse. It sits above the layer controllers, one level below the host/top-level run interface.

## Interface
- N_LAYERS, 3: number of layer controllers sequenced (≥1)
- T_STEPS, 8: timesteps per inference (≥1)
- TW, 4: timestep counter width; T_STEPS ≤ 2^TW
- LW, 2: layer index width; N_LAYERS ≤ 2^LW
- TO_CYCLES, 4096: watchdog limit per layer, in cycles (used only with SNN_SEQ_WDOG_EN)
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  inference request; sampled only in IDLE
- layer_done  in  N_LAYERS  per-layer done pulses from the layer controllers
- layer_start  out  N_LAYERS  one-hot, one-cycle start pulse to the selected layer
- mem_clr  out  1  one-cycle membrane/spike-buffer clear to all layers
- tstep  out  TW  current timestep index
- layer_idx  out  LW  currently selected layer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky watchdog error flag

## Operation
- States: IDLE, CLR, ISSUE, WAIT, ADV, FIN. Registered state; all outputs are Moore-decoded from the current state or registered counters.
- IDLE: run=1 → CLR. Also sets tstep=0 and layer_idx=0, and clears err.
- CLR: mem_clr=1 → ISSUE.
- ISSUE: layer_start[layer_idx]=1 → WAIT.
- WAIT: layer_done[layer_idx]=1 → ADV; otherwise stay in WAIT.
- ADV:
  - If layer_idx < N_LAYERS-1: layer_idx+1 → ISSUE.
  - Else if tstep < T_STEPS-1: tstep+1, layer_idx=0 → ISSUE.
  - Else → FIN.
- FIN: done=1 → IDLE. tstep and layer_idx hold their final values until the next run.
- layer_done bits of non-selected layers are ignored in every state.
- layer_done arriving in any state other than WAIT is ignored, including a done in the ISSUE cycle.
- run while busy is ignored; requests are not queued.
- N_LAYERS=1 and T_STEPS=1 are legal; ADV goes directly to FIN.
- Counter compare uses full-width equality against parameter-1 constants. There is no wrap-around: counters never increment past their terminal value.
- Reset (any time, including mid-inference): state=IDLE, layer_start=0, mem_clr=0, done=0, busy=0, err=0, tstep=0, layer_idx=0.
- Layers in flight during a reset are not aborted by this block; their reset is the system's responsibility.

## Timing
- run sampled high at edge 0:
  - mem_clr high in cycle 1
  - layer_start[0] high in cycle 2
  - WAIT from cycle 3
- Per layer: ISSUE (1) + WAIT (≥1) + ADV (1).
  - A layer_done sampled k cycles after its start (k≥1) gives the next layer_start k+2 cycles after the previous one.
- done is high one cycle after the final ADV. busy falls in the cycle after done.
- Minimum total cycles from run to done: 2 + N_LAYERS·T_STEPS·3 + 1.

## Configuration
- SNN_SEQ_WDOG_EN defined:
  - A counter runs in WAIT and resets on entry to WAIT.
  - If it reaches TO_CYCLES without the selected layer_done, err is set (sticky until the next accepted run) and the FSM goes to FIN, so done still pulses.
- SNN_SEQ_WDOG_EN undefined:
  - No counter is built and err is tied 0.
  - WAIT waits indefinitely.

## Structure
- Package snn_seq_pkg holds:
  - state encoding localparams: IDLE=0, CLR=1, ISSUE=2, WAIT=3, ADV=4, FIN=5 (3 bits)
  - default TO_CYCLES
- Sub-module snn_seq_wdog (enable/clear/terminal-count counter) is instantiated only under SNN_SEQ_WDOG_EN.

## Test plan
- N_LAYERS=3, T_STEPS=2, each layer returns done 5 cycles after its start → layer_start order 0,1,2,0,1,2; tstep 0,0,0,1,1,1; exactly one mem_clr and one done; err=0.
- Non-selected layer_done[2] pulsed while waiting on layer 0 → no advance; layer_start[1] only after layer_done[0].
- run pulsed mid-inference and again in the FIN cycle → ignored; exactly one done; the next run in IDLE starts a new inference with mem_clr.
- rst_n asserted in WAIT at tstep=1 → all outputs 0 immediately; after release, run restarts from tstep=0, layer_idx=0.
- N_LAYERS=1, T_STEPS=1, done 1 cycle after start → run to done in 6 cycles.
- SNN_SEQ_WDOG_EN, TO_CYCLES=16, layer 1 never responds → err=1 and done after 16 WAIT cycles; the next run clears err.
